// File: rtl/masked_seq_detect.sv
// Serial pattern detector with per-bit care mask, runtime-loadable pattern/mask/mode,
// valid qualifier, overlap/non-overlap mode and a saturating hit counter.
module masked_seq_detect #(
    parameter int unsigned             SEQ_LEN = 9,
    parameter logic [SEQ_LEN-1:0]      PATTERN = 9'b011000110,
    parameter logic [SEQ_LEN-1:0]      MASK    = 9'b111000111,
    parameter logic                    OVERLAP = 1'b1,
    parameter int unsigned             CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               a,
    input  logic               a_valid,
    input  logic               cfg_we,
    input  logic [SEQ_LEN-1:0] cfg_pattern,
    input  logic [SEQ_LEN-1:0] cfg_mask,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed
);

    localparam int unsigned FillW = (SEQ_LEN > 2) ? $clog2(SEQ_LEN) : 1;
    localparam logic [FillW-1:0] FillLast = FillW'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        StFill,
        StArmed
    } state_e;

    state_e             state_q, state_d;
    // Oldest history bit is shifted out before it can ever be compared, so it is not stored.
    logic [SEQ_LEN-2:0] hist_q, hist_d;
    logic [FillW-1:0]   fill_q, fill_d;
    logic [SEQ_LEN-1:0] pat_q, pat_d;
    logic [SEQ_LEN-1:0] mask_q, mask_d;
    logic               ovl_q, ovl_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [SEQ_LEN-1:0] window;
    logic               window_full;
    logic               hit;
    logic [CNT_W-1:0]   cnt_base;

    always_comb begin
        window      = {hist_q, a};
        window_full = (state_q == StArmed) || (fill_q == FillLast);
        hit         = a_valid && !cfg_we && window_full
                      && (((window ^ pat_q) & mask_q) == '0);
    end

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        mask_d  = mask_q;
        ovl_d   = ovl_q;
        match_d = 1'b0;

        if (cfg_we) begin
            pat_d   = cfg_pattern;
            mask_d  = cfg_mask;
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = StFill;
        end else if (a_valid) begin
            hist_d  = window[SEQ_LEN-2:0];
            match_d = hit;
            unique case (state_q)
                StFill: begin
                    if (fill_q == FillLast) begin
                        if (hit && !ovl_q) begin
                            fill_d = '0;
                        end else begin
                            state_d = StArmed;
                        end
                    end else begin
                        fill_d = fill_q + FillW'(1);
                    end
                end
                StArmed: begin
                    if (hit && !ovl_q) begin
                        fill_d  = '0;
                        state_d = StFill;
                    end
                end
                default: state_d = StFill;
            endcase
        end
    end

    // Clear applies before the increment, so a coincident hit leaves a count of one.
    always_comb begin
        cnt_base = cnt_clr ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (hit && (cnt_base != CntMax)) begin
            cnt_d = cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFill;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= PATTERN;
            mask_q  <= MASK;
            ovl_q   <= OVERLAP;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            ovl_q   <= ovl_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign armed     = (state_q == StArmed);

endmodule

// File: doc/masked_seq_detect.md
# masked_seq_detect

Parametrised serial pattern detector with per-bit don't-care masking, runtime-loadable pattern/mask, overlap/non-overlap mode, a valid qualifier and a saturating hit counter. It watches a 1-bit serial stream and pulses `match` for one cycle after the last bit of a qualifying window is sampled. It replaces the fixed 9-bit "011xxx110" detector in the serial-protocol front end. It also suppresses false hits on reset-time history, because it arms only after a full window of real bits has been seen.

## Interface
- `SEQ_LEN`, 9: window length in bits, ≥2.
- `PATTERN`, 9'b011000110: reset pattern; MSB = oldest bit.
- `MASK`, 9'b111000111: reset care-mask; 1 = compare bit, 0 = don't care.
- `OVERLAP`, 1: reset mode; 1 = overlapping, 0 = non-overlapping.
- `CNT_W`, 8: hit counter width.
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  synchronous active-low reset.
- `a`  in  1  serial data bit.
- `a_valid`  in  1  `a` is sampled only when high.
- `cfg_we`  in  1  load `cfg_pattern`/`cfg_mask`/`cfg_overlap` and restart detection.
- `cfg_pattern`  in  SEQ_LEN  new pattern, MSB = oldest.
- `cfg_mask`  in  SEQ_LEN  new care-mask.
- `cfg_overlap`  in  1  new mode.
- `cnt_clr`  in  1  clear `match_cnt`.
- `match`  out  1  registered one-cycle hit pulse.
- `match_cnt`  out  CNT_W  saturating count of hits.
- `armed`  out  1  window full; comparisons active.

## Operation
- **Reset** (`rst_n` = 0 at posedge):
  - history = 0, fill = 0, state FILL.
  - `match` = 0, `match_cnt` = 0, `armed` = 0.
  - Active pattern/mask/overlap = `PATTERN`/`MASK`/`OVERLAP`.
- **History:** on each posedge with `a_valid` = 1, history <= {history[SEQ_LEN-2:0], a}. Cycles with `a_valid` = 0 leave history unchanged.
- **Candidate window:** w = {history[SEQ_LEN-2:0], a}. A hit requires ((w ^ pattern) & mask) == 0, `a_valid` = 1, and the window full.
- **FSM, two states:**
  - FILL: fill counter counts valid bits. A valid bit with fill = SEQ_LEN-1 completes the window. That bit is compared and the state moves to ARMED.
  - ARMED: every valid bit is compared.
  - On a hit with overlap = 0, fill is cleared and the state returns to FILL, so the next hit needs SEQ_LEN fresh bits.
  - On a hit with overlap = 1, the state stays ARMED.
- `armed` = (state == ARMED), registered.
- **Hit result:** `match` <= hit. `match_cnt` increments on a hit and saturates at 2^CNT_W-1.
- **`cfg_we` = 1:**
  - Latches the new pattern, mask and mode.
  - Clears history and fill; state goes to FILL; `match` <= 0.
  - Any `a_valid` bit in the same cycle is discarded.
  - `match_cnt` is preserved.
- **`cnt_clr`:** clears `match_cnt`. If a hit occurs in the same cycle, the result is 1 (clear, then increment).
- **Priority:** `rst_n` > `cfg_we` > normal operation.
- **All-zero mask:** every valid bit hits once armed. In overlap mode that is one hit per bit; in non-overlap mode it is one hit per SEQ_LEN bits.

## Timing
- **Latency:** the last bit is sampled at edge k; `match` is high for the cycle after edge k, for exactly one cycle unless edge k+1 also produces a hit.
- **Back-to-back hits:** in overlap mode, consecutive valid cycles can give back-to-back hits; `match` then stays high across consecutive cycles.
- **Counter:** `match_cnt` updates on the same edge as `match`.
- **Config timing:** after `cfg_we` at edge k, the first bit that can complete a window is the SEQ_LEN-th valid bit sampled after edge k.
- **No combinational paths:** no input reaches any output combinationally.
- **Reset mid-stream:** any partial window is discarded; a pending `match` is cleared at that edge.

## Test plan
- **Defaults, 9-bit stream 0,1,1,1,0,1,1,1,0 after reset:** `match` pulses once, one cycle after the 9th bit; `match_cnt` = 1.
- **False hit on reset zeros:** with `cfg_pattern` = 0 and `cfg_mask` = all-ones loaded, feed 8 zeros → no `match`. The 9th zero → `match` = 1 and `armed` = 1.
- **Overlap, pattern 9'b101010101, mask all-ones, stream of 11 alternating bits starting with 1:**
  - Overlap = 1: hits on the 9th and 11th bits; `match_cnt` = 2.
  - Overlap = 0: one hit, and `armed` drops after it.
- **Valid gaps:** insert `a_valid` = 0 cycles, with arbitrary `a`, between default-pattern bits → same single hit, delayed accordingly; idle bits are never shifted in.
- **`cfg_we` mid-window:** assert `cfg_we` with `a_valid` = 1 after 5 bits → that bit is dropped, `armed` = 0, and the following 9 bits matching the new pattern give exactly one hit.
- **Counter:** with CNT_W = 2, force 5 hits → `match_cnt` saturates at 3. Then `cnt_clr` coincident with a hit → `match_cnt` = 1.
